// File: rtl/spatz_issue_queue.sv
// In-order issue queue for decoded vector requests, with a RAW/WAW busy scoreboard over the vector registers.
// Optional macro SPATZ_ISSUE_BYPASS_EN: an empty queue forwards a hazard-free request to issue_* in the same cycle.
module spatz_issue_queue #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned ReqWidth = 64,
  localparam int unsigned NrVRegs = 32,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ReqWidth-1:0] req_payload_i,
  input  logic [4:0]          req_vd_i,
  input  logic [4:0]          req_vs1_i,
  input  logic [4:0]          req_vs2_i,
  input  logic                req_use_vd_i,
  input  logic                req_use_vs1_i,
  input  logic                req_use_vs2_i,
  output logic                issue_valid_o,
  input  logic                issue_ready_i,
  output logic [ReqWidth-1:0] issue_payload_o,
  input  logic                rsp_valid_i,
  input  logic [4:0]          rsp_vd_i,
  output logic [NrVRegs-1:0]  busy_o,
  output logic [CntW-1:0]     count_o,
  output logic                sb_err_o
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  // Handshake: a transfer happens on a cycle where valid and ready are both high at the clock edge;
  // valid never depends on ready, and a presented payload holds until it is taken.

  logic [ReqWidth-1:0] pl_q   [Depth];
  logic [4:0]          vd_q   [Depth];
  logic [4:0]          vs1_q  [Depth];
  logic [4:0]          vs2_q  [Depth];
  logic                uvd_q  [Depth];
  logic                uvs1_q [Depth];
  logic                uvs2_q [Depth];

  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [NrVRegs-1:0] busy_q, busy_d;
  logic               sb_err_q, sb_err_d;

  logic               head_hazard;
  logic               head_valid;
  logic               bypass;
  logic               push;
  logic               pop;
  logic [NrVRegs-1:0] set_vec;
  logic [NrVRegs-1:0] clr_vec;

  function automatic logic has_hazard(input logic [NrVRegs-1:0] b,
                                      input logic [4:0] vd, input logic [4:0] vs1,
                                      input logic [4:0] vs2, input logic use_vd,
                                      input logic use_vs1, input logic use_vs2);
    return (use_vs1 && b[vs1]) || (use_vs2 && b[vs2]) || (use_vd && b[vd]);
  endfunction

  always_comb begin
    head_hazard = has_hazard(busy_q, vd_q[rd_ptr_q], vs1_q[rd_ptr_q], vs2_q[rd_ptr_q],
                             uvd_q[rd_ptr_q], uvs1_q[rd_ptr_q], uvs2_q[rd_ptr_q]);
    head_valid  = (count_q != '0) && !head_hazard && !flush_i;
    req_ready_o = !rst_i && (count_q < DepthC) && !flush_i;
`ifdef SPATZ_ISSUE_BYPASS_EN
    bypass = (count_q == '0) && req_valid_i && !flush_i && !rst_i &&
             !has_hazard(busy_q, req_vd_i, req_vs1_i, req_vs2_i,
                         req_use_vd_i, req_use_vs1_i, req_use_vs2_i);
`else
    bypass = 1'b0;
`endif
    issue_valid_o   = head_valid || bypass;
    issue_payload_o = bypass ? req_payload_i : pl_q[rd_ptr_q];
    // A bypassed request that is taken immediately never occupies a slot.
    push = req_valid_i && req_ready_o && !(bypass && issue_ready_i);
    pop  = head_valid && issue_ready_i;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (pop && uvd_q[rd_ptr_q]) set_vec[vd_q[rd_ptr_q]] = 1'b1;
    if (bypass && issue_ready_i && req_use_vd_i) set_vec[req_vd_i] = 1'b1;
    if (rsp_valid_i && busy_q[rsp_vd_i]) clr_vec[rsp_vd_i] = 1'b1;
    // Clear first, then set, so a new writer wins over a retire of the same vreg.
    busy_d   = (busy_q & ~clr_vec) | set_vec;
    sb_err_d = sb_err_q | (rsp_valid_i && !busy_q[rsp_vd_i]);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pl_q[wr_ptr_q]   <= req_payload_i;
      vd_q[wr_ptr_q]   <= req_vd_i;
      vs1_q[wr_ptr_q]  <= req_vs1_i;
      vs2_q[wr_ptr_q]  <= req_vs2_i;
      uvd_q[wr_ptr_q]  <= req_use_vd_i;
      uvs1_q[wr_ptr_q] <= req_use_vs1_i;
      uvs2_q[wr_ptr_q] <= req_use_vs2_i;
    end
  end

  assign busy_o   = busy_q;
  assign count_o  = count_q;
  assign sb_err_o = sb_err_q;

endmodule

// File: tb/tb_spatz_issue_queue.sv
// Bench for spatz_issue_queue: queue-level reference model checked every cycle, plus directed scenarios.
module tb_spatz_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_payload = '0;
  logic [4:0]  req_vd = '0, req_vs1 = '0, req_vs2 = '0;
  logic        req_use_vd = 1'b0, req_use_vs1 = 1'b0, req_use_vs2 = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [63:0] issue_payload;
  logic        rsp_valid = 1'b0;
  logic [4:0]  rsp_vd = '0;
  logic [31:0] busy;
  logic [2:0]  count;
  logic        sb_err;

  int total = 0;
  int bad = 0;

  spatz_issue_queue #(.Depth(4), .ReqWidth(64)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_payload_i(req_payload),
    .req_vd_i(req_vd), .req_vs1_i(req_vs1), .req_vs2_i(req_vs2),
    .req_use_vd_i(req_use_vd), .req_use_vs1_i(req_use_vs1), .req_use_vs2_i(req_use_vs2),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_payload_o(issue_payload),
    .rsp_valid_i(rsp_valid), .rsp_vd_i(rsp_vd),
    .busy_o(busy), .count_o(count), .sb_err_o(sb_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] pl;
    logic [4:0]  vd, vs1, vs2;
    logic        uvd, uvs1, uvs2;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] m_busy = '0;
  logic        m_err = 1'b0;

  function automatic req_t cur_req();
    req_t r;
    r.pl = req_payload; r.vd = req_vd; r.vs1 = req_vs1; r.vs2 = req_vs2;
    r.uvd = req_use_vd; r.uvs1 = req_use_vs1; r.uvs2 = req_use_vs2;
    return r;
  endfunction

  function automatic logic haz(req_t r, logic [31:0] b);
    return (r.uvs1 && b[r.vs1]) || (r.uvs2 && b[r.vs2]) || (r.uvd && b[r.vd]);
  endfunction

  function automatic logic e_ready();
    return !rst && (exp_q.size() < DEPTH) && !flush;
  endfunction

  function automatic logic e_bypass();
`ifdef SPATZ_ISSUE_BYPASS_EN
    return !rst && (exp_q.size() == 0) && req_valid && !flush && !haz(cur_req(), m_busy);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic e_valid();
    if (e_bypass()) return 1'b1;
    if (rst || flush || exp_q.size() == 0) return 1'b0;
    return !haz(exp_q[0], m_busy);
  endfunction

  function automatic logic [63:0] e_payload();
    return e_bypass() ? req_payload : exp_q[0].pl;
  endfunction

  task automatic model_step();
    req_t        inc;
    logic [31:0] nb;
    logic        bp, vld, rdy;
    if (rst) begin
      exp_q.delete();
      m_busy = '0;
      m_err  = 1'b0;
    end else begin
      inc = cur_req();
      bp  = e_bypass();
      vld = e_valid();
      rdy = e_ready();
      nb  = m_busy;
      if (rsp_valid) begin
        if (!m_busy[rsp_vd]) m_err = 1'b1;
        else nb[rsp_vd] = 1'b0;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (vld && issue_ready) begin
          if (bp) begin
            if (inc.uvd) nb[inc.vd] = 1'b1;
          end else begin
            if (exp_q[0].uvd) nb[exp_q[0].vd] = 1'b1;
            exp_q.delete(0);
          end
        end
        if (req_valid && rdy && !(bp && issue_ready)) exp_q.push_back(inc);
      end
      m_busy = nb;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("m_ready", 64'(req_ready), 64'(e_ready()));
    chk("m_valid", 64'(issue_valid), 64'(e_valid()));
    if (e_valid()) chk("m_payload", issue_payload, e_payload());
    chk("m_count", 64'(count), 64'(exp_q.size()));
    chk("m_busy", 64'(busy), 64'(m_busy));
    chk("m_err", 64'(sb_err), 64'(m_err));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [63:0] p, input logic [4:0] vd, input logic [4:0] vs1,
                      input logic [4:0] vs2, input logic uvd, input logic uvs1, input logic uvs2);
    req_payload = p; req_vd = vd; req_vs1 = vs1; req_vs2 = vs2;
    req_use_vd = uvd; req_use_vs1 = uvs1; req_use_vs2 = uvs2;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic retire(input logic [4:0] vd);
    rsp_valid = 1'b1;
    rsp_vd = vd;
    cyc();
    rsp_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 chk("rel_ready", 64'(req_ready), 64'd1);

    // Fill / drain, three rounds to wrap the pointers.
    issue_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) push(64'hA000 + 64'(r * 16 + i), 5'(i), 5'(i + 8), 5'(i + 16), 1'b0, 1'b0, 1'b0);
      #1 chk("fill_count", 64'(count), 64'd4);
      if (r == 0) begin
        req_payload = 64'hDEAD;
        req_valid = 1'b1;
        #1 chk("full_ready", 64'(req_ready), 64'd0);
        cyc();
        req_valid = 1'b0;
        chk("full_count", 64'(count), 64'd4);
      end
      issue_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1 chk("drain_valid", 64'(issue_valid), 64'd1);
        chk("drain_payload", issue_payload, 64'hA000 + 64'(r * 16 + i));
        cyc();
      end
      issue_ready = 1'b0;
      chk("drain_count", 64'(count), 64'd0);
    end

    // RAW on v2.
    issue_ready = 1'b1;
    push(64'hB0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(64'hB1, 5'd9, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("raw_busy2", 64'(busy[2]), 64'd1);
    chk("raw_hold", 64'(issue_valid), 64'd0);
    cyc();
    chk("raw_hold2", 64'(issue_valid), 64'd0);
    rsp_valid = 1'b1; rsp_vd = 5'd2;
    #1 chk("raw_no_fwd", 64'(issue_valid), 64'd0);
    cyc();
    rsp_valid = 1'b0;
    #1 chk("raw_release", 64'(issue_valid), 64'd1);
    chk("raw_payload", issue_payload, 64'hB1);
    cyc();
    chk("raw_count", 64'(count), 64'd0);
    chk("raw_busy_clr", 64'(busy), 64'd0);

    // Spurious retire.
    chk("err_before", 64'(sb_err), 64'd0);
    retire(5'd7);
    chk("err_set", 64'(sb_err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    cyc();
    chk("err_sticky", 64'(sb_err), 64'd1);

    // WAW on v5, then a retire of v5 in the same cycle as a new writer of v5 issues.
    push(64'hC0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(64'hC1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("waw_hold", 64'(issue_valid), 64'd0);
    chk("waw_busy5", 64'(busy[5]), 64'd1);
    retire(5'd5);
    #1 chk("waw_release", 64'(issue_valid), 64'd1);
    retire(5'd5);
    chk("waw_set_wins", 64'(busy[5]), 64'd1);
    chk("waw_count", 64'(count), 64'd0);

    // Flush with two entries and v3 busy.
    push(64'hD0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    issue_ready = 1'b0;
    chk("fl_busy3", 64'(busy[3]), 64'd1);
    push(64'hD1, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0, 1'b0);
    push(64'hD2, 5'd13, 5'd14, 5'd15, 1'b0, 1'b0, 1'b0);
    chk("fl_count2", 64'(count), 64'd2);
    flush = 1'b1;
    req_payload = 64'hF0; req_valid = 1'b1;
    #1 chk("fl_ready", 64'(req_ready), 64'd0);
    chk("fl_valid", 64'(issue_valid), 64'd0);
    cyc();
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("fl_count", 64'(count), 64'd0);
    chk("fl_busy_kept", 64'(busy), 64'h28);
    retire(5'd3);
    chk("fl_retire3", 64'(busy), 64'h20);

    // Asynchronous reset mid-stream with three queued entries.
    for (int i = 0; i < 3; i++) push(64'hE0 + 64'(i), 5'(20 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #1 rst = 1'b1;
    #1 chk("arst_count", 64'(count), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(issue_valid), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_err", 64'(sb_err), 64'd0);
    cyc();
    rst = 1'b0;
    #1 chk("arel_ready", 64'(req_ready), 64'd1);

`ifdef SPATZ_ISSUE_BYPASS_EN
    issue_ready = 1'b1;
    req_payload = 64'hCAFE; req_vd = 5'd1; req_use_vd = 1'b0;
    req_use_vs1 = 1'b0; req_use_vs2 = 1'b0; req_valid = 1'b1;
    #1 chk("byp_valid", 64'(issue_valid), 64'd1);
    chk("byp_payload", issue_payload, 64'hCAFE);
    cyc();
    req_valid = 1'b0;
    chk("byp_count", 64'(count), 64'd0);
    issue_ready = 1'b0;
`endif

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
